// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fft_pkg
// Brief    : State codes and width-generic saturation for the butterfly block.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int unsigned c_SAT_W = 40;

    typedef enum logic [3:0] {
        LOAD_REW = 4'd0,
        LOAD_IMW = 4'd1,
        LOAD_REB = 4'd2,
        LOAD_IMB = 4'd3,
        LOAD_REA = 4'd4,
        LOAD_IMA = 4'd5,
        CALC0    = 4'd6,
        CALC1    = 4'd7,
        CALC2    = 4'd8,
        CALC3    = 4'd9,
        SUM      = 4'd10,
        DISP_REY = 4'd11,
        DISP_IMY = 4'd12,
        DISP_REZ = 4'd13,
        DISP_IMZ = 4'd14
    } fft_state_e;

    // Clamp x into the signed range of a w-bit number (w < c_SAT_W).
    function automatic logic signed [c_SAT_W-1:0] sat_clip(
        input logic signed [c_SAT_W-1:0] x,
        input int unsigned               w
    );
        logic signed [c_SAT_W-1:0] hi;
        logic signed [c_SAT_W-1:0] lo;
        logic signed [c_SAT_W-1:0] res;
        hi = (c_SAT_W'(1) << (w - 1)) - c_SAT_W'(1);
        lo = ~hi;
        if (x > hi)      res = hi;
        else if (x < lo) res = lo;
        else             res = x;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_round_sat.sv
`default_nettype none
// ============================================================================
// Module   : fft_round_sat
// Brief    : Round-half-up arithmetic shift followed by saturation to OUT_W.
// Revision : 1.0 - initial release
// ============================================================================
module fft_round_sat
    import fft_pkg::*;
#(
    parameter int IN_W  = 17,
    parameter int SHIFT = 7,
    parameter int OUT_W = 10
) (
    input  logic signed [IN_W-1:0]  i_din,
    output logic signed [OUT_W-1:0] o_dout,
    output logic                    o_sat
);

    logic signed [c_SAT_W-1:0] w_ext;
    logic signed [c_SAT_W-1:0] w_rnd;
    logic signed [c_SAT_W-1:0] w_clip;

    assign w_ext = c_SAT_W'(i_din);

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [c_SAT_W-1:0] c_HALF = c_SAT_W'(1) << (SHIFT - 1);
            assign w_rnd = (w_ext + c_HALF) >>> SHIFT;
        end else begin : g_pass
            assign w_rnd = w_ext;
        end
    endgenerate

    assign w_clip = sat_clip(w_rnd, OUT_W);
    assign o_dout = OUT_W'(w_clip);
    assign o_sat  = (w_clip != w_rnd);

endmodule
`default_nettype wire

// File: rtl/fft_butterfly_seq.sv
`default_nettype none
// ============================================================================
// Module   : fft_butterfly_seq
// Brief    : Operator-stepped radix-2 butterfly Y=A+WB, Z=A-WB, one multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module fft_butterfly_seq
    import fft_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 7
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              ReadyIn,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              Inverse,
    output logic [DATA_W-1:0] result,
    output logic              Overflow,
    output logic              Busy,
    output logic [3:0]        Phase
);

    localparam int c_PROD_W = 2 * DATA_W;
    localparam int c_ACC_W  = 2 * DATA_W + 1;
    localparam int c_WB_W   = c_ACC_W - FRAC_W;
    localparam int c_Y_W    = c_WB_W + 1;
    localparam logic signed [DATA_W-1:0] c_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] c_MAX = ~c_MIN;

    fft_state_e r_state;
    fft_state_e w_state_nxt;

    logic                       r_ready_q;
    logic                       w_edge;
    logic signed [DATA_W-1:0]   r_rew, r_imw, r_reb, r_imb, r_rea, r_ima;
    logic                       r_inv;
    logic signed [c_ACC_W-1:0]  r_acc_re, r_acc_im;
    logic signed [DATA_W-1:0]   r_yim, r_zre, r_zim;
    logic [DATA_W-1:0]          r_result;
    logic                       r_ovf;

    logic signed [DATA_W-1:0]   w_imw_neg, w_imw_eff;
    logic signed [DATA_W-1:0]   w_mul_a, w_mul_b;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_ACC_W-1:0]  w_prod_ext;
    logic signed [c_WB_W-1:0]   w_wb_re, w_wb_im;
    logic                       w_sat_wbre, w_sat_wbim;
    logic signed [c_Y_W-1:0]    w_sum [4];
    logic signed [DATA_W-1:0]   w_out [4];
    logic [3:0]                 w_sat_out;

    assign w_edge = ReadyIn & ~r_ready_q;

    // Conjugate twiddle: the most negative code has no positive counterpart.
    assign w_imw_neg = (r_imw == c_MIN) ? c_MAX : -r_imw;
    assign w_imw_eff = r_inv ? w_imw_neg : r_imw;

    always_comb begin
        w_mul_a = r_rew;
        w_mul_b = r_reb;
        case (r_state)
            CALC1:   begin w_mul_a = w_imw_eff; w_mul_b = r_imb; end
            CALC2:   begin w_mul_a = r_rew;     w_mul_b = r_imb; end
            CALC3:   begin w_mul_a = w_imw_eff; w_mul_b = r_reb; end
            default: ;
        endcase
    end

    assign w_prod     = c_PROD_W'(w_mul_a) * c_PROD_W'(w_mul_b);
    assign w_prod_ext = c_ACC_W'(w_prod);

    fft_round_sat #(.IN_W(c_ACC_W), .SHIFT(FRAC_W), .OUT_W(c_WB_W)) u_rnd_re (
        .i_din  (r_acc_re),
        .o_dout (w_wb_re),
        .o_sat  (w_sat_wbre)
    );

    fft_round_sat #(.IN_W(c_ACC_W), .SHIFT(FRAC_W), .OUT_W(c_WB_W)) u_rnd_im (
        .i_din  (r_acc_im),
        .o_dout (w_wb_im),
        .o_sat  (w_sat_wbim)
    );

    assign w_sum[0] = c_Y_W'(r_rea) + c_Y_W'(w_wb_re);
    assign w_sum[1] = c_Y_W'(r_ima) + c_Y_W'(w_wb_im);
    assign w_sum[2] = c_Y_W'(r_rea) - c_Y_W'(w_wb_re);
    assign w_sum[3] = c_Y_W'(r_ima) - c_Y_W'(w_wb_im);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_yz
            fft_round_sat #(.IN_W(c_Y_W), .SHIFT(0), .OUT_W(DATA_W)) u_sat (
                .i_din  (w_sum[gi]),
                .o_dout (w_out[gi]),
                .o_sat  (w_sat_out[gi])
            );
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (!nReset) r_state <= LOAD_REW;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD_REW: if (w_edge) w_state_nxt = LOAD_IMW;
            LOAD_IMW: if (w_edge) w_state_nxt = LOAD_REB;
            LOAD_REB: if (w_edge) w_state_nxt = LOAD_IMB;
            LOAD_IMB: if (w_edge) w_state_nxt = LOAD_REA;
            LOAD_REA: if (w_edge) w_state_nxt = LOAD_IMA;
            LOAD_IMA: if (w_edge) w_state_nxt = CALC0;
            CALC0:    w_state_nxt = CALC1;
            CALC1:    w_state_nxt = CALC2;
            CALC2:    w_state_nxt = CALC3;
            CALC3:    w_state_nxt = SUM;
            SUM:      w_state_nxt = DISP_REY;
            DISP_REY: if (w_edge) w_state_nxt = DISP_IMY;
            DISP_IMY: if (w_edge) w_state_nxt = DISP_REZ;
            DISP_REZ: if (w_edge) w_state_nxt = DISP_IMZ;
            DISP_IMZ: if (w_edge) w_state_nxt = LOAD_REW;
            default:  w_state_nxt = LOAD_REW;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            r_ready_q <= 1'b1;
            r_rew     <= '0;
            r_imw     <= '0;
            r_reb     <= '0;
            r_imb     <= '0;
            r_rea     <= '0;
            r_ima     <= '0;
            r_inv     <= 1'b0;
            r_acc_re  <= '0;
            r_acc_im  <= '0;
            r_yim     <= '0;
            r_zre     <= '0;
            r_zim     <= '0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_ready_q <= ReadyIn;
            case (r_state)
                LOAD_REW: if (w_edge) begin r_rew <= $signed(dataIn); r_result <= dataIn; r_ovf <= 1'b0; end
                LOAD_IMW: if (w_edge) begin r_imw <= $signed(dataIn); r_result <= dataIn; end
                LOAD_REB: if (w_edge) begin r_reb <= $signed(dataIn); r_result <= dataIn; end
                LOAD_IMB: if (w_edge) begin r_imb <= $signed(dataIn); r_result <= dataIn; end
                LOAD_REA: if (w_edge) begin r_rea <= $signed(dataIn); r_result <= dataIn; end
                LOAD_IMA: if (w_edge) begin r_ima <= $signed(dataIn); r_result <= dataIn; end
                CALC0: begin
                    r_inv    <= Inverse;
                    r_acc_re <= w_prod_ext;
                end
                CALC1: r_acc_re <= r_acc_re - w_prod_ext;
                CALC2: r_acc_im <= w_prod_ext;
                CALC3: r_acc_im <= r_acc_im + w_prod_ext;
                SUM: begin
                    r_result <= w_out[0];
                    r_yim    <= w_out[1];
                    r_zre    <= w_out[2];
                    r_zim    <= w_out[3];
                    r_ovf    <= r_ovf | (|w_sat_out) | w_sat_wbre | w_sat_wbim;
                end
                DISP_REY: if (w_edge) r_result <= r_yim;
                DISP_IMY: if (w_edge) r_result <= r_zre;
                DISP_REZ: if (w_edge) r_result <= r_zim;
                default: ;
            endcase
        end
    end

    assign result   = r_result;
    assign Overflow = r_ovf;
    assign Busy     = (r_state == CALC0) || (r_state == CALC1) || (r_state == CALC2) ||
                      (r_state == CALC3) || (r_state == SUM);
    assign Phase    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fft_butterfly_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_butterfly_seq
// Brief    : Randomized scoreboard bench for fft_butterfly_seq (8-bit, Q1.7).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_butterfly_seq;

    localparam int DW = 8;
    localparam int FW = 7;

    logic          clk = 1'b0;
    logic          nReset;
    logic          ReadyIn;
    logic [DW-1:0] dataIn;
    logic          Inverse;
    logic [DW-1:0] result;
    logic          Overflow;
    logic          Busy;
    logic [3:0]    Phase;

    always #5 clk = ~clk;

    fft_butterfly_seq #(.DATA_W(DW), .FRAC_W(FW)) dut (
        .Clock    (clk),
        .nReset   (nReset),
        .ReadyIn  (ReadyIn),
        .dataIn   (dataIn),
        .Inverse  (Inverse),
        .result   (result),
        .Overflow (Overflow),
        .Busy     (Busy),
        .Phase    (Phase)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] q_val [$];
    int            q_ovf [$];
    int            q_tag [$];
    logic [3:0]    mon_prev = 4'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v, input int ovf, input int tag);
        q_val.push_back(v);
        q_ovf.push_back(ovf);
        q_tag.push_back(tag);
    endtask

    // Reference arithmetic on plain integers.
    function automatic longint clamp(input longint x);
        longint hi;
        longint lo;
        hi = longint'(2) ** (DW - 1) - 1;
        lo = -hi - 1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic longint round_half_up(input longint x);
        longint d;
        longint y;
        longint q;
        d = longint'(2) ** FW;
        y = x + d / 2;
        q = y / d;
        if ((y % d != 0) && (y < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model(input logic [DW-1:0] wr, wi, br, bi, ar, ai, input bit inv,
                         output longint s [4], output bit ov);
        longint w_r, w_i, b_r, b_i, a_r, a_i, rewb, imwb;
        longint raw [4];
        w_r = longint'($signed(wr));
        w_i = longint'($signed(wi));
        b_r = longint'($signed(br));
        b_i = longint'($signed(bi));
        a_r = longint'($signed(ar));
        a_i = longint'($signed(ai));
        if (inv) w_i = clamp(-w_i);
        rewb = round_half_up(w_r * b_r - w_i * b_i);
        imwb = round_half_up(w_r * b_i + w_i * b_r);
        raw[0] = a_r + rewb;
        raw[1] = a_i + imwb;
        raw[2] = a_r - rewb;
        raw[3] = a_i - imwb;
        ov = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s[k] = clamp(raw[k]);
            if (s[k] != raw[k]) ov = 1'b1;
        end
    endtask

    task automatic pulse(input logic [DW-1:0] d);
        @(negedge clk);
        dataIn  = d;
        ReadyIn = 1'b1;
        @(negedge clk);
        ReadyIn = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_bfly(input logic [DW-1:0] wr, wi, br, bi, ar, ai,
                            input bit inv, input bit busy_pulse, input bit abort);
        longint        s [4];
        bit            ov;
        int            cyc;
        logic [DW-1:0] ops [6];
        model(wr, wi, br, bi, ar, ai, inv, s, ov);
        ops = '{wr, wi, br, bi, ar, ai};
        for (int k = 0; k < 5; k++) begin
            push(ops[k], -1, k + 1);
            pulse(ops[k]);
            if (k == 0) check("ovf_clear_on_rew", {31'd0, Overflow}, 32'd0);
        end
        Inverse = inv;
        push(ai, -1, 6);
        push(DW'(s[0]), int'(ov), 11);
        push(DW'(s[1]), -1, 12);
        push(DW'(s[2]), -1, 13);
        push(DW'(s[3]), -1, 14);
        @(negedge clk);
        dataIn  = ai;
        ReadyIn = 1'b1;
        @(negedge clk);
        ReadyIn = 1'b0;
        cyc = 0;
        check("busy_in_calc0", {31'd0, Busy}, 32'd1);
        while (Phase != 4'd11 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) Inverse = ~inv;
            if (busy_pulse) begin
                if (cyc == 1 || cyc == 4) ReadyIn = 1'b1;
                if (cyc == 2 || cyc == 5) ReadyIn = 1'b0;
            end
            if (abort && cyc == 2) begin
                q_val.delete();
                q_ovf.delete();
                q_tag.delete();
                nReset  = 1'b0;
                ReadyIn = 1'b0;
                @(negedge clk);
                check("abort_phase",    {28'd0, Phase},    32'd0);
                check("abort_result",   {24'd0, result},   32'd0);
                check("abort_busy",     {31'd0, Busy},     32'd0);
                check("abort_overflow", {31'd0, Overflow}, 32'd0);
                nReset = 1'b1;
                repeat (2) @(negedge clk);
                return;
            end
        end
        check("rey_latency", cyc, 32'd5);
        ReadyIn = 1'b0;
        repeat (4) pulse(DW'($urandom));
    endtask

    // Monitor: each forward step into a load-next or display state presents a value.
    initial begin
        logic [DW-1:0] v;
        int            o;
        int            t;
        forever begin
            @(negedge clk);
            if ((Phase == mon_prev + 4'd1) &&
                ((Phase >= 4'd1 && Phase <= 4'd6) || (Phase >= 4'd11 && Phase <= 4'd14))) begin
                if (q_val.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: phase %0d result 0x%0h with nothing expected", Phase, result);
                end else begin
                    v = q_val.pop_front();
                    o = q_ovf.pop_front();
                    t = q_tag.pop_front();
                    check("phase_order", {28'd0, Phase}, t);
                    check($sformatf("result_phase%0d", t), {24'd0, result}, {24'd0, v});
                    if (o >= 0) check("overflow_at_rey", {31'd0, Overflow}, o);
                end
            end
            mon_prev = Phase;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nReset  = 1'b0;
        ReadyIn = 1'b0;
        dataIn  = '0;
        Inverse = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_phase",    {28'd0, Phase},    32'd0);
        check("reset_result",   {24'd0, result},   32'd0);
        check("reset_overflow", {31'd0, Overflow}, 32'd0);
        check("reset_busy",     {31'd0, Busy},     32'd0);
        nReset = 1'b1;
        repeat (2) @(negedge clk);

        run_bfly(8'h7F, 8'h00, 8'd20, 8'h00, 8'd10, 8'h00, 1'b0, 1'b0, 1'b0);
        run_bfly(8'h00, 8'h7F, 8'd20, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        run_bfly(8'h00, 8'h7F, 8'd20, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        run_bfly(8'h7F, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0);
        run_bfly(8'h7F, 8'h00, 8'd20, 8'h00, 8'd10, 8'h00, 1'b0, 1'b1, 1'b0);
        run_bfly(8'h00, 8'h80, 8'd20, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        run_bfly(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        run_bfly(8'h35, 8'hC2, 8'h71, 8'h0E, 8'h22, 8'hF0, 1'b1, 1'b0, 1'b1);
        run_bfly(8'h7F, 8'h00, 8'd20, 8'h00, 8'd10, 8'h00, 1'b0, 1'b0, 1'b0);

        // ReadyIn held high across reset release must not step the sequencer.
        nReset  = 1'b0;
        ReadyIn = 1'b1;
        repeat (5) @(negedge clk);
        nReset = 1'b1;
        repeat (45) @(negedge clk);
        check("hold_high_advance", {31'd0, (Phase <= 4'd1)}, 32'd1);
        ReadyIn = 1'b0;
        nReset  = 1'b0;
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            run_bfly(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                     DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", q_val.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_butterfly_seq.md
FFT_BUTTERFLY_SEQ -- requirements
Module: fft_butterfly_seq

Interface
REQ-001 Parameter DATA_W, default 8: signed two's-complement width of every operand and result; SHALL be 4..16.
REQ-002 Parameter FRAC_W, default 7: fractional bits of twiddle W (Q format); SHALL satisfy 1 <= FRAC_W < DATA_W.
REQ-003 Clock  input  1: single clock; all state on rising edge.
REQ-004 nReset  input  1: reset, synchronous, active-low.
REQ-005 ReadyIn  input  1: operator step strobe, already debounced; only rising edges are significant.
REQ-006 dataIn  input  DATA_W: signed operand, sampled on the ReadyIn edge in load states.
REQ-007 Inverse  input  1: 1 = use conjugate twiddle (IFFT mode).
REQ-008 result  output  DATA_W: echoed operand in load states, selected output in display states.
REQ-009 Overflow  output  1: sticky; set when any output saturated in the current butterfly.
REQ-010 Busy  output  1: high during CALC0..CALC3 and SUM.
REQ-011 Phase  output  4: current state encoding, for LED/debug display.

Function
REQ-012 Edge detect: edge = ReadyIn & ~ReadyIn_q; ReadyIn_q SHALL reset to 1, so an input held high through reset release gives no edge.
REQ-013 States: LOAD_REW, LOAD_IMW, LOAD_REB, LOAD_IMB, LOAD_REA, LOAD_IMA, CALC0..CALC3, SUM, DISP_REY, DISP_IMY, DISP_REZ, DISP_IMZ.
REQ-014 Load states: on an edge, capture dataIn into the named register, drive it on result, advance to the next state.
REQ-015 Loading ReW SHALL clear Overflow.
REQ-016 After LOAD_IMA: CALC0..CALC3 and SUM advance one per clock with no edge needed; edges during Busy are discarded, not queued.
REQ-017 Inverse is sampled in CALC0 and held until SUM completes; changes at other times have no effect on the current butterfly.
REQ-018 Under Inverse, ImW' = -ImW, with -(-2^(DATA_W-1)) saturating to 2^(DATA_W-1)-1; otherwise ImW' = ImW.
REQ-019 A single signed DATA_W x DATA_W multiplier is shared across CALC0..CALC3, in order: ReW*ReB, ImW'*ImB, ReW*ImB, ImW'*ReB.
REQ-020 Products are 2*DATA_W bits; ReWB = ReW*ReB - ImW'*ImB and ImWB = ReW*ImB + ImW'*ReB, accumulated at 2*DATA_W+1 bits with no loss.
REQ-021 Each accumulation is rounded half-up: add 2^(FRAC_W-1), then arithmetic shift right FRAC_W.
REQ-022 SUM: compute Y = A + WB and Z = A - WB at full width, saturate each component to the DATA_W signed range, and set Overflow if any of the four saturated.
REQ-023 The ReY result SHALL appear on result on the 5th clock after the edge-capture of ImA, in state DISP_REY.
REQ-024 Display states advance on each edge: DISP_REY -> DISP_IMY -> DISP_REZ -> DISP_IMZ -> LOAD_REW. result holds the selected value; no edge means no change.
REQ-025 Operand registers persist until overwritten; a new butterfly overwrites all six.

Reset
REQ-026 On nReset low at a clock edge, from any state including mid-CALC: state = LOAD_REW, result = 0, Overflow = 0, Busy = 0, and all operand, product and output registers are cleared to 0.
REQ-027 Phase SHALL read the LOAD_REW code (0) out of reset.

Structure
REQ-028 Package fft_pkg SHALL hold the state enum with explicit 4-bit codes, and a saturate function parameterised by width.
REQ-029 One sub-module, fft_round_sat: combinational round-shift and saturation, reused for the WB and Y/Z paths.

Verification (DATA_W=8, FRAC_W=7)
REQ-030 Load W=(0x7F,0), B=(20,0), A=(10,0), Inverse=0 -> outputs ReY=30, ImY=0, ReZ=0xF6 (-10), ImZ=0, Overflow=0.
REQ-031 Load W=(0,0x7F), B=(20,0), A=(0,0): Inverse=0 -> ImY=20, ImZ=0xEC. Repeat with Inverse=1 -> ImY=0xEC, ImZ=20.
REQ-032 Load W=(0x7F,0), B=(0x7F,0), A=(0x7F,0) -> ReY saturates to 0x7F, ReZ=1, Overflow=1. Next ReW load clears Overflow.
REQ-033 Assert nReset in CALC2 -> next clock: Phase=0, result=0, Busy=0. A subsequent full load sequence gives correct results.
REQ-034 Hold ReadyIn high for 50 clocks, including across reset release -> at most one state advance. Edges pulsed during Busy -> ignored; DISP_REY still reached at capture+5.
